// File: rtl/id_operand_issue_pkg.sv
// Shared defaults and types for the ID-stage operand/issue unit.
package id_operand_issue_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int ADDR_W_DEF       = 5;
    localparam int PAY_W_DEF        = 16;
    localparam int NUM_FWD_DEF      = 2;
    localparam int LOAD_USE_CYC_DEF = 1;

    typedef enum logic [1:0] {
        SRC_IMM  = 2'd0,
        SRC_ZERO = 2'd1,
        SRC_FWD  = 2'd2,
        SRC_RF   = 2'd3
    } op_src_e;

endpackage

// File: rtl/id_operand_issue_fwd_mux.sv
// Priority operand selector: immediate, $zero, youngest forwarding hit, register file.
module fwd_mux
    import id_operand_issue_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic                      ren,
    input  logic [ADDR_W-1:0]         raddr,
    input  logic [DATA_W-1:0]         imm,
    input  logic [DATA_W-1:0]         rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_wrn,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         operand
);

    op_src_e           src;
    logic [DATA_W-1:0] fwd_data;

    // Scan from oldest to youngest so the lowest matching index is the last writer.
    always_comb begin
        src      = SRC_RF;
        fwd_data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wrn[i] && (fwd_waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
                src      = SRC_FWD;
                fwd_data = fwd_wdata[i*DATA_W +: DATA_W];
            end
        end
        if (!ren) begin
            src = SRC_IMM;
        end else if (raddr == '0) begin
            src = SRC_ZERO;
        end
    end

    always_comb begin
        operand = '0;
        unique case (src)
            SRC_IMM:  operand = imm;
            SRC_ZERO: operand = '0;
            SRC_FWD:  operand = fwd_data;
            SRC_RF:   operand = rf_rdata;
            default:  operand = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_issue.sv
// ID-stage operand/issue unit: operand selection, load-use scoreboard and the ID/EX register.
module id_operand_issue
    import id_operand_issue_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int PAY_W        = PAY_W_DEF,
    parameter int NUM_FWD      = NUM_FWD_DEF,
    parameter int LOAD_USE_CYC = LOAD_USE_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      dec_ren1,
    input  logic                      dec_ren2,
    input  logic [ADDR_W-1:0]         dec_raddr1,
    input  logic [ADDR_W-1:0]         dec_raddr2,
    input  logic                      dec_wrn,
    input  logic [ADDR_W-1:0]         dec_waddr,
    input  logic                      dec_is_load,
    input  logic [DATA_W-1:0]         dec_imm,
    input  logic [PAY_W-1:0]          dec_pay,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_wrn,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_op1,
    output logic [DATA_W-1:0]         out_op2,
    output logic                      out_wrn,
    output logic [ADDR_W-1:0]         out_waddr,
    output logic                      out_is_load,
    output logic [PAY_W-1:0]          out_pay,
    output logic                      stall_req
);

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              sb_v    [LOAD_USE_CYC];
    logic [ADDR_W-1:0] sb_addr [LOAD_USE_CYC];
    logic              sb_hit1;
    logic              sb_hit2;
    logic              hazard;
    logic              adv;
    logic              issue;

    fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_mux1 (
        .ren       (dec_ren1),
        .raddr     (dec_raddr1),
        .imm       (dec_imm),
        .rf_rdata  (rf_rdata1),
        .fwd_wrn   (fwd_wrn),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .operand   (op1)
    );

    fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_FWD (NUM_FWD)
    ) u_mux2 (
        .ren       (dec_ren2),
        .raddr     (dec_raddr2),
        .imm       (dec_imm),
        .rf_rdata  (rf_rdata2),
        .fwd_wrn   (fwd_wrn),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .operand   (op2)
    );

    always_comb begin
        sb_hit1 = 1'b0;
        sb_hit2 = 1'b0;
        for (int j = 0; j < LOAD_USE_CYC; j++) begin
            if (sb_v[j] && (sb_addr[j] == dec_raddr1)) sb_hit1 = 1'b1;
            if (sb_v[j] && (sb_addr[j] == dec_raddr2)) sb_hit2 = 1'b1;
        end
    end

    // A pending load result beats any forwarding match, since the forward would be stale.
    assign hazard = in_valid &
                    ((dec_ren1 & (dec_raddr1 != '0) & sb_hit1) |
                     (dec_ren2 & (dec_raddr2 != '0) & sb_hit2));

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & ~hazard & ~flush;
    assign issue     = in_valid & in_ready;
    assign stall_req = hazard & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LOAD_USE_CYC; j++) begin
                sb_v[j]    <= 1'b0;
                sb_addr[j] <= '0;
            end
        end else if (flush) begin
            for (int j = 0; j < LOAD_USE_CYC; j++) begin
                sb_v[j] <= 1'b0;
            end
        end else if (adv) begin
            for (int j = LOAD_USE_CYC - 1; j > 0; j--) begin
                sb_v[j]    <= sb_v[j-1];
                sb_addr[j] <= sb_addr[j-1];
            end
            sb_v[0]    <= issue & dec_is_load & dec_wrn & (dec_waddr != '0);
            sb_addr[0] <= dec_waddr;
        end
    end

    // Flush clears the slot even when EX is accepting it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_wrn     <= 1'b0;
            out_waddr   <= '0;
            out_is_load <= 1'b0;
            out_pay     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= issue;
            if (issue) begin
                out_op1     <= op1;
                out_op2     <= op2;
                out_wrn     <= dec_wrn;
                out_waddr   <= dec_waddr;
                out_is_load <= dec_is_load;
                out_pay     <= dec_pay;
            end
        end
    end

endmodule

// File: tb/tb_id_operand_issue.sv
// Directed bench for id_operand_issue, one instance per load-use depth.
module tb_id_operand_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic        dec_ren1, dec_ren2;
    logic [4:0]  dec_raddr1, dec_raddr2;
    logic        dec_wrn;
    logic [4:0]  dec_waddr;
    logic        dec_is_load;
    logic [31:0] dec_imm;
    logic [15:0] dec_pay;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [1:0]  fwd_wrn;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic        flush;
    logic        out_ready;

    logic        out_valid, out_valid2;
    logic [31:0] out_op1, out_op1_2;
    logic [31:0] out_op2, out_op2_2;
    logic        out_wrn, out_wrn2;
    logic [4:0]  out_waddr, out_waddr2;
    logic        out_is_load, out_is_load2;
    logic [15:0] out_pay, out_pay2;
    logic        stall_req, stall_req2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_operand_issue #(.LOAD_USE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dec_ren1(dec_ren1), .dec_ren2(dec_ren2), .dec_raddr1(dec_raddr1), .dec_raddr2(dec_raddr2),
        .dec_wrn(dec_wrn), .dec_waddr(dec_waddr), .dec_is_load(dec_is_load), .dec_imm(dec_imm),
        .dec_pay(dec_pay), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_wrn(fwd_wrn),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2), .out_wrn(out_wrn),
        .out_waddr(out_waddr), .out_is_load(out_is_load), .out_pay(out_pay), .stall_req(stall_req)
    );

    id_operand_issue #(.LOAD_USE_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .dec_ren1(dec_ren1), .dec_ren2(dec_ren2), .dec_raddr1(dec_raddr1), .dec_raddr2(dec_raddr2),
        .dec_wrn(dec_wrn), .dec_waddr(dec_waddr), .dec_is_load(dec_is_load), .dec_imm(dec_imm),
        .dec_pay(dec_pay), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_wrn(fwd_wrn),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_op1(out_op1_2), .out_op2(out_op2_2), .out_wrn(out_wrn2),
        .out_waddr(out_waddr2), .out_is_load(out_is_load2), .out_pay(out_pay2), .stall_req(stall_req2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic r1, input logic [4:0] a1,
                                 input logic r2, input logic [4:0] a2, input logic wr,
                                 input logic [4:0] wa, input logic ld, input logic [31:0] imm,
                                 input logic [15:0] pay);
        in_valid    = v;
        dec_ren1    = r1;
        dec_raddr1  = a1;
        dec_ren2    = r2;
        dec_raddr2  = a2;
        dec_wrn     = wr;
        dec_waddr   = wa;
        dec_is_load = ld;
        dec_imm     = imm;
        dec_pay     = pay;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid2 = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rf_rdata1 = '0; rf_rdata2 = '0; fwd_wrn = '0; fwd_waddr = '0; fwd_wdata = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_op1", out_op1, 32'd0);
        checkOutput("reset_pay", {16'b0, out_pay}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall_req}, 32'd0);

        $display("[TB] forwarding priority and operand sources");
        fwd_wrn = 2'b11; fwd_waddr = {5'd5, 5'd5}; fwd_wdata = {32'h22, 32'h11};
        rf_rdata1 = 32'h99;
        applyStimulus(1, 1, 5, 0, 0, 1, 7, 0, 32'h1234, 16'hA5A5);
        checkOutput("fwd_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("fwd_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("fwd_op1_youngest", out_op1, 32'h11);
        checkOutput("fwd_op2_imm", out_op2, 32'h1234);
        checkOutput("fwd_waddr", {27'b0, out_waddr}, 32'd7);
        checkOutput("fwd_pay", {16'b0, out_pay}, 32'hA5A5);

        fwd_wrn = 2'b01; fwd_waddr = {5'd5, 5'd0}; fwd_wdata = {32'h22, 32'hFFFF};
        rf_rdata2 = 32'h55;
        applyStimulus(1, 1, 0, 1, 9, 1, 7, 0, 32'h0, 16'h0);
        tick();
        checkOutput("zero_op1", out_op1, 32'h0);
        checkOutput("zero_op2_rf", out_op2, 32'h55);

        fwd_wrn = 2'b10; fwd_waddr = {5'd5, 5'd0}; rf_rdata2 = 32'h66;
        applyStimulus(1, 1, 5, 1, 6, 1, 7, 0, 32'h0, 16'h0);
        tick();
        checkOutput("fwd_op1_older", out_op1, 32'h22);
        checkOutput("rf_op2", out_op2, 32'h66);

        $display("[TB] load-use, depth 1");
        fwd_wrn = 2'b00;
        applyStimulus(1, 1, 1, 0, 0, 1, 3, 1, 32'h0, 16'h0);
        tick();
        checkOutput("lw_is_load", {31'b0, out_is_load}, 32'd1);
        applyStimulus(1, 1, 3, 0, 0, 1, 8, 0, 32'h4, 16'h0);
        checkOutput("lu1_stall", {31'b0, stall_req}, 32'd1);
        checkOutput("lu1_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        checkOutput("lu1_bubble", {31'b0, out_valid}, 32'd0);
        fwd_wrn = 2'b10; fwd_waddr = {5'd3, 5'd0}; fwd_wdata = {32'hBEEF, 32'h0};
        #1;
        checkOutput("lu1_stall_clear", {31'b0, stall_req}, 32'd0);
        checkOutput("lu1_in_ready_back", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("lu1_add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("lu1_add_op1", out_op1, 32'hBEEF);
        checkOutput("lu1_add_waddr", {27'b0, out_waddr}, 32'd8);
        fwd_wrn = 2'b00;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        tick();

        $display("[TB] back-pressure");
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 32'h77, 16'h0);
        tick();
        checkOutput("bp_x_op1", out_op1, 32'h77);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c < 2) applyStimulus(1, 1, 4, 0, 0, 1, 11, 0, 32'h88, 16'h0);
            else       applyStimulus(1, 0, 0, 0, 0, 1, 11, 0, 32'h88, 16'h0);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_stall", {31'b0, stall_req}, (c < 2) ? 32'd1 : 32'd0);
            tick();
            checkOutput("bp_valid_hold", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_op1_hold", out_op1, 32'h77);
            checkOutput("bp_waddr_hold", {27'b0, out_waddr}, 32'd4);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_y_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_y_op1", out_op1, 32'h88);
        checkOutput("bp_y_waddr", {27'b0, out_waddr}, 32'd11);

        $display("[TB] flush with a load pending");
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 32'h0, 16'h0);
        tick();
        rf_rdata1 = 32'h5555; flush = 1'b1;
        applyStimulus(1, 1, 5, 0, 0, 1, 9, 0, 32'h0, 16'h0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("flush_stall", {31'b0, stall_req}, 32'd0);
        tick();
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;
        #1;
        checkOutput("post_flush_stall", {31'b0, stall_req}, 32'd0);
        tick();
        checkOutput("post_flush_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("post_flush_op1", out_op1, 32'h5555);
        checkOutput("post_flush_waddr", {27'b0, out_waddr}, 32'd9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        tick();

        $display("[TB] load-use, depth 2");
        applyStimulus(0, 1, 1, 0, 0, 1, 3, 1, 32'h0, 16'h0);
        in_valid2 = 1'b1;
        tick();
        checkOutput("lu2_lw_valid", {31'b0, out_valid2}, 32'd1);
        applyStimulus(0, 1, 3, 0, 0, 1, 8, 0, 32'h4, 16'h0);
        checkOutput("lu2_stall_a", {31'b0, stall_req2}, 32'd1);
        tick();
        checkOutput("lu2_bubble_a", {31'b0, out_valid2}, 32'd0);
        checkOutput("lu2_stall_b", {31'b0, stall_req2}, 32'd1);
        tick();
        checkOutput("lu2_bubble_b", {31'b0, out_valid2}, 32'd0);
        fwd_wrn = 2'b10; fwd_waddr = {5'd3, 5'd0}; fwd_wdata = {32'hCAFE, 32'h0};
        #1;
        checkOutput("lu2_stall_clear", {31'b0, stall_req2}, 32'd0);
        checkOutput("lu2_in_ready", {31'b0, in_ready2}, 32'd1);
        tick();
        checkOutput("lu2_add_valid", {31'b0, out_valid2}, 32'd1);
        checkOutput("lu2_add_op1", out_op1_2, 32'hCAFE);
        in_valid2 = 1'b0; fwd_wrn = 2'b00;

        $display("[TB] reset during a stall");
        applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 32'h3, 16'h1F);
        tick();
        applyStimulus(1, 1, 6, 0, 0, 1, 8, 0, 32'h4, 16'h2E);
        checkOutput("rst_pre_stall", {31'b0, stall_req}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_op1", out_op1, 32'd0);
        checkOutput("rst_waddr", {27'b0, out_waddr}, 32'd0);
        checkOutput("rst_is_load", {31'b0, out_is_load}, 32'd0);
        checkOutput("rst_pay", {16'b0, out_pay}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall_req}, 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
